// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter family: direction encodings and
// the build-time overflow policy selector.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

endpackage

// File: rtl/counter_step_calc.sv
// Combinational next-count calculator: applies one signed step within 0..max_val,
// wrapping or clamping, and flags which bound was crossed.
module counter_step_calc
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned STEP_W   = 4,
  parameter int unsigned SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0]  count_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [WIDTH-1:0]  max_val_i,
  input  logic              up_down_i,
  output logic              valid_o,
  output logic [WIDTH-1:0]  next_o,
  output logic              wrap_o,
  output logic              ovf_evt_o,
  output logic              udf_evt_o
);

  // One extra bit above the widest operand so sums and max_val+1 never lose a carry.
  localparam int unsigned CW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

  logic [CW-1:0] cnt_ext;
  logic [CW-1:0] stp_ext;
  logic [CW-1:0] max_ext;
  logic [CW-1:0] mod_ext;
  logic [CW-1:0] sum_ext;
  logic [CW-1:0] res_ext;
  logic          out_of_range;

  assign cnt_ext      = {{(CW - WIDTH){1'b0}}, count_i};
  assign stp_ext      = {{(CW - STEP_W){1'b0}}, step_i};
  assign max_ext      = {{(CW - WIDTH){1'b0}}, max_val_i};
  assign mod_ext      = max_ext + {{(CW - 1){1'b0}}, 1'b1};
  assign sum_ext      = cnt_ext + stp_ext;
  assign out_of_range = (cnt_ext > max_ext);

  // A zero step or a step larger than the whole range is treated as a hold.
  assign valid_o = (stp_ext != '0) && (stp_ext <= max_ext);

  always_comb begin
    res_ext   = cnt_ext;
    wrap_o    = 1'b0;
    ovf_evt_o = 1'b0;
    udf_evt_o = 1'b0;
    if (up_down_i == DIR_UP) begin
      if (out_of_range) begin
        res_ext   = (SATURATE == MODE_SAT) ? max_ext : '0;
        wrap_o    = 1'b1;
        ovf_evt_o = 1'b1;
      end else if (sum_ext > max_ext) begin
        res_ext   = (SATURATE == MODE_SAT) ? max_ext : (sum_ext - mod_ext);
        wrap_o    = 1'b1;
        ovf_evt_o = 1'b1;
      end else begin
        res_ext = sum_ext;
      end
    end else begin
      if (out_of_range) begin
        res_ext   = max_ext;
        wrap_o    = 1'b1;
        udf_evt_o = 1'b1;
      end else if (stp_ext > cnt_ext) begin
        res_ext   = (SATURATE == MODE_SAT) ? '0 : (cnt_ext + mod_ext - stp_ext);
        wrap_o    = 1'b1;
        udf_evt_o = 1'b1;
      end else begin
        res_ext = cnt_ext - stp_ext;
      end
    end
  end

  assign next_o = res_ext[WIDTH-1:0];

endmodule

// File: rtl/counter_up_down_param.sv
// Parametrised up/down counter with programmable modulus, variable step, load,
// terminal-count pulse and sticky overflow/underflow flags.
module counter_up_down_param
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned STEP_W   = 4,
  parameter int unsigned SATURATE = MODE_WRAP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  max_val,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              ovf,
  output logic              udf
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic             step_valid;
  logic [WIDTH-1:0] step_next;
  logic             step_wrap;
  logic             step_ovf;
  logic             step_udf;

  counter_step_calc #(
    .WIDTH    (WIDTH),
    .STEP_W   (STEP_W),
    .SATURATE (SATURATE)
  ) u_step_calc (
    .count_i   (count_q),
    .step_i    (step),
    .max_val_i (max_val),
    .up_down_i (up_down),
    .valid_o   (step_valid),
    .next_o    (step_next),
    .wrap_o    (step_wrap),
    .ovf_evt_o (step_ovf),
    .udf_evt_o (step_udf)
  );

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    // Clear first so a same-cycle set event below wins.
    ovf_d   = ovf_q & ~clr_flags;
    udf_d   = udf_q & ~clr_flags;
    if (load) begin
      count_d = (load_val > max_val) ? max_val : load_val;
    end else if (en && step_valid) begin
      count_d = step_next;
      tc_d    = step_wrap;
      ovf_d   = ovf_d | step_ovf;
      udf_d   = udf_d | step_udf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  assign udf   = udf_q;

endmodule

// File: doc/counter_up_down_param.md
Name: counter_up_down_param

Overview:
Parametrised successor to the 8-bit up/down counter. Adds runtime direction, programmable modulus (max_val), variable step, synchronous load, enable, and a build-time wrap or saturate mode. Also provides a terminal-count pulse and sticky overflow/underflow flags. Used as the general event/address counter in the sequential-logic library.

Parameters:
WIDTH, 8, bit width of count, max_val and load_val
STEP_W, 4, bit width of step
SATURATE, 0, 0 = wrap modulo (max_val+1); 1 = clamp at 0 / max_val

Ports:
clk  input  1  rising-edge clock, single domain
rst  input  1  synchronous, active-high reset
en  input  1  count enable; when low, count holds
up_down  input  1  1 = count up, 0 = count down
step  input  STEP_W  increment/decrement amount; 0 = hold
max_val  input  WIDTH  upper count limit (inclusive); count range 0..max_val
load  input  1  synchronous load of load_val
load_val  input  WIDTH  value to load
clr_flags  input  1  clears ovf/udf
count  output  WIDTH  registered count value
tc  output  1  registered 1-cycle pulse: a wrap or clip happened on this update
ovf  output  1  sticky: an up-count wrapped or clipped at max_val
udf  output  1  sticky: a down-count wrapped or clipped at 0

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst). All outputs are registered.
- Reset values: count=0, tc=0, ovf=0, udf=0.
- Priority: rst > load > en. All outputs update on the rising edge after the inputs are sampled (1-cycle latency).
- Load: count <= min(load_val, max_val); tc=0; flags unchanged.
- Hold: en=0, or step=0, or step > max_val → count holds and tc=0.
- Internal arithmetic is WIDTH+1 bits, so there is no silent carry loss.
- Up-count, count+step <= max_val: count <= count+step.
- Up-count, count+step > max_val:
  - Wrap mode: count <= count+step-(max_val+1).
  - Saturate mode: count <= max_val.
  - In both modes tc=1 and ovf is set.
- Down-count, step <= count: count <= count-step.
- Down-count, step > count:
  - Wrap mode: count <= count+(max_val+1)-step.
  - Saturate mode: count <= 0.
  - In both modes tc=1 and udf is set.
- Saturate mode: tc reasserts on every enabled cycle that clips, including when count is already sitting at the bound.
- Out-of-range count (count > max_val because max_val was lowered) on an enabled step:
  - Up, wrap mode: count <= 0.
  - Up, saturate mode: count <= max_val.
  - Down (either mode): count <= max_val.
  - In all these cases tc=1 and the matching flag (ovf or udf) is set.
- Full-range case: max_val = 2^WIDTH-1 gives a plain modulo-2^WIDTH counter.
- clr_flags: clears ovf and udf. If a set event occurs in the same cycle, set wins.
- Reset during a load or count: reset dominates; count=0 and all flags are cleared.
- up_down may change on any cycle; the new direction applies from that edge.

Decomposition:
- Shared package counter_pkg:
  - DIR_UP=1'b1 and DIR_DOWN=1'b0 constants.
  - MODE_WRAP / MODE_SAT encodings for SATURATE.
- Sub-module counter_step_calc (combinational):
  - Inputs: count, step, max_val, up_down.
  - Outputs: next value, wrap/clip indication, ovf_evt, udf_evt.
  - The top level holds the count, tc and flag registers and the priority logic.

Test Plan:
1. Reset and full-range up-count (WIDTH=8). Assert rst for 2 cycles → count=0, tc=ovf=udf=0. Then en=1, up, step=1, max_val=255: count goes 1,2,…,255,0. tc pulses exactly on the cycle count becomes 0; ovf=1 afterwards.
2. Modulus with step (wrap mode). max_val=9, step=3, up from 0 → count 3,6,9,2. tc=1 only on the 9→2 update. Switch to down, step=3 → 2→9 (2+10-3), udf=1.
3. Saturate mode (SATURATE=1). max_val=200, load 198, up, step=5 → count=200, tc=1, ovf=1; further enabled cycles hold 200 with tc=1. Down from 2 with step 3 → count=0, udf=1.
4. Load priority and clamp. load=1, en=1, load_val=250, max_val=99 → count=99, tc=0. Then en=0 for 5 cycles → count stays 99.
5. Flag handling. With ovf=1, assert clr_flags alone → ovf=0. Assert clr_flags together with a wrapping up-count → ovf=1. Step=12 with max_val=9 → count holds, tc=0.
6. Reset mid-operation and shrinking limit. rst=1 together with load=1 → count=0, flags cleared. Count to 8 with max_val=9, lower max_val to 5, one up step in wrap mode → count=0, tc=1, ovf=1.
